// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI RAM master: opcodes, word widths and
// FSM state encodings.
package spi_ram_pkg;

   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;

   localparam int CMD_W  = 10;
   localparam int DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      SETUP      = 3'd1,
      SHIFT_OUT  = 3'd2,
      TURNAROUND = 3'd3,
      SHIFT_IN   = 3'd4,
      GAP        = 3'd5
   } state_t;

endpackage

// File: rtl/spi_ram_master_bit_counter.sv
// Loadable down-counter with a terminal flag; times every multi-cycle
// phase of the SPI frame.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   i_load      - load i_load_val (has priority over i_dec)
//   i_load_val  - value to load (phase length minus one)
//   i_dec       - decrement by one
//   o_tc        - count is zero (last cycle of the phase)
module spi_bit_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic         o_tc
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_tc = (r_count == '0);

endmodule

// File: rtl/spi_ram_master.sv
// SPI master for the 10-bit command / 8-bit readback RAM link. Frames one
// command per transaction on SS_n/MOSI (MSB first) on the system clock and,
// for read-data commands, captures the 8-bit reply from MISO.
// Ports:
//   clk, rst_n          - system clock, async active-low reset
//   cmd_valid/ready     - command handshake (ready only in IDLE)
//   cmd_data[9:0]       - {opcode, payload}
//   rd_valid, rd_data   - one-cycle pulse with the returned byte
//   busy                - !cmd_ready
//   SS_n, MOSI, MISO    - serial link (SS_n and MOSI are registered)
module spi_ram_master
   import spi_ram_pkg::*;
#(
   parameter int TA_CYCLES      = 2,
   parameter int GAP_CYCLES     = 1,
   parameter int MISO_LSB_FIRST = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [CMD_W-1:0]  cmd_data,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              SS_n,
   output logic              MOSI,
   input  logic              MISO
);

   // Phase lengths are loaded as (length - 1); TA and GAP wrap at 3 bits.
   localparam logic [2:0] TA3     = 3'(TA_CYCLES);
   localparam logic [3:0] TA_LD   = {1'b0, 3'(TA_CYCLES - 1)};
   localparam logic [3:0] GAP_LD  = {1'b0, 3'(GAP_CYCLES - 1)};
   localparam logic [3:0] OUT_LD  = 4'(CMD_W - 1);
   localparam logic [3:0] IN_LD   = 4'(DATA_W - 1);

   state_t              r_state, w_next;
   logic [CMD_W-1:0]    r_sh;
   logic [1:0]          r_op;
   logic [DATA_W-1:0]   r_rx, w_rx_next;
   logic                r_ss_n, r_mosi, r_rd_valid;
   logic [DATA_W-1:0]   r_rd_data;

   logic                w_ss_n_nxt, w_mosi_nxt;
   logic                w_sh_load, w_sh_shift, w_rx_shift, w_rd_done;
   logic                w_cnt_load, w_cnt_dec, w_cnt_tc;
   logic [3:0]          w_cnt_val;

   spi_bit_counter #(.W(4)) u_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_cnt_load),
      .i_load_val (w_cnt_val),
      .i_dec      (w_cnt_dec),
      .o_tc       (w_cnt_tc)
   );

   assign w_rx_next = (MISO_LSB_FIRST != 0) ? {MISO, r_rx[DATA_W-1:1]}
                                            : {r_rx[DATA_W-2:0], MISO};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state plus the values SS_n/MOSI must show in the next cycle,
   // so both pins come straight from flops.
   always_comb begin
      w_next     = r_state;
      w_ss_n_nxt = 1'b1;
      w_mosi_nxt = 1'b0;
      w_sh_load  = 1'b0;
      w_sh_shift = 1'b0;
      w_rx_shift = 1'b0;
      w_rd_done  = 1'b0;
      w_cnt_load = 1'b0;
      w_cnt_val  = '0;
      w_cnt_dec  = 1'b0;
      case (r_state)
         IDLE: begin
            if (cmd_valid) begin
               w_next     = SETUP;
               w_sh_load  = 1'b1;
               w_ss_n_nxt = 1'b0;
               w_mosi_nxt = cmd_data[CMD_W-1];
            end
         end
         SETUP: begin
            // cmd[9] is presented twice: once here, once as the first shift bit.
            w_next     = SHIFT_OUT;
            w_cnt_load = 1'b1;
            w_cnt_val  = OUT_LD;
            w_ss_n_nxt = 1'b0;
            w_mosi_nxt = r_sh[CMD_W-1];
            w_sh_shift = 1'b1;
         end
         SHIFT_OUT: begin
            if (w_cnt_tc) begin
               if (r_op == OP_RD_DATA) begin
                  w_ss_n_nxt = 1'b0;
                  w_cnt_load = 1'b1;
                  if (TA3 == 3'd0) begin
                     w_next    = SHIFT_IN;
                     w_cnt_val = IN_LD;
                  end else begin
                     w_next    = TURNAROUND;
                     w_cnt_val = TA_LD;
                  end
               end else begin
                  w_next     = GAP;
                  w_cnt_load = 1'b1;
                  w_cnt_val  = GAP_LD;
               end
            end else begin
               w_cnt_dec  = 1'b1;
               w_ss_n_nxt = 1'b0;
               w_mosi_nxt = r_sh[CMD_W-1];
               w_sh_shift = 1'b1;
            end
         end
         TURNAROUND: begin
            w_ss_n_nxt = 1'b0;
            if (w_cnt_tc) begin
               w_next     = SHIFT_IN;
               w_cnt_load = 1'b1;
               w_cnt_val  = IN_LD;
            end else begin
               w_cnt_dec = 1'b1;
            end
         end
         SHIFT_IN: begin
            w_rx_shift = 1'b1;
            if (w_cnt_tc) begin
               w_next     = GAP;
               w_cnt_load = 1'b1;
               w_cnt_val  = GAP_LD;
               w_rd_done  = 1'b1;
            end else begin
               w_cnt_dec  = 1'b1;
               w_ss_n_nxt = 1'b0;
            end
         end
         GAP: begin
            if (w_cnt_tc) begin
               w_next = IDLE;
            end else begin
               w_cnt_dec = 1'b1;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ss_n     <= 1'b1;
         r_mosi     <= 1'b0;
         r_sh       <= '0;
         r_op       <= '0;
         r_rx       <= '0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         r_ss_n     <= w_ss_n_nxt;
         r_mosi     <= w_mosi_nxt;
         r_rd_valid <= w_rd_done;
         if (w_sh_load) begin
            r_sh <= cmd_data;
            r_op <= cmd_data[CMD_W-1:CMD_W-2];
         end else if (w_sh_shift) begin
            r_sh <= {r_sh[CMD_W-2:0], 1'b0};
         end
         if (w_rx_shift) begin
            r_rx <= w_rx_next;
         end
         // The final MISO bit is folded in directly so rd_data lands in the
         // first GAP cycle together with rd_valid.
         if (w_rd_done) begin
            r_rd_data <= w_rx_next;
         end
      end
   end

   assign cmd_ready = (r_state == IDLE);
   assign busy      = ~cmd_ready;
   assign SS_n      = r_ss_n;
   assign MOSI      = r_mosi;
   assign rd_valid  = r_rd_valid;
   assign rd_data   = r_rd_data;

endmodule
